// File: rtl/ob_cmd_deser.sv
// ob_cmd_deser: packs a sop/eop framed beat stream into one command word per
// packet for the order-book ingress. Malformed packets are discarded and
// flagged on err_vld_r. The assembled command is held until the book's
// ingress queue has room.
// Optional build macro OB_CMD_DESER_STATS_EN adds saturating push/error
// counters (cmd_cnt_r, err_cnt_r).
module ob_cmd_deser #(
   parameter int IN_W  = 32,
   parameter int CMD_W = 96
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_vld,
   input  logic             in_sop,
   input  logic             in_eop,
   input  logic [IN_W-1:0]  in_data,
   output logic             in_rdy,
   input  logic             cmd_full_r,
   output logic             cmd_vld_r,
   output logic [CMD_W-1:0] cmd_r,
   output logic             err_vld_r
`ifdef OB_CMD_DESER_STATS_EN
   ,
   output logic [15:0]      cmd_cnt_r,
   output logic [15:0]      err_cnt_r
`endif
);

   localparam int BEATS = (CMD_W + IN_W - 1) / IN_W;
   localparam int ASM_W = BEATS * IN_W;
   localparam int CNT_W = $clog2(BEATS + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

   typedef enum logic [1:0] {IDLE, ASM, DROP, HOLD} state_t;

   state_t           state_r, state_nxt;
   logic [CNT_W-1:0] cnt_r, cnt_nxt;
   logic [ASM_W-1:0] asm_r;
   logic             wr_en;
   logic [CNT_W-1:0] wr_idx;
   logic             err_nxt;
   logic             push_nxt;
   logic             acc;

   // Input readiness depends only on registered state, never on in_vld.
   assign in_rdy = (state_r != HOLD);
   assign acc    = in_vld & in_rdy;
   // Beats beyond CMD_W on the last beat are simply not exposed.
   assign cmd_r  = asm_r[CMD_W-1:0];

   // Framing decode: next state, beat write enable, error and push strobes.
   always_comb begin
      state_nxt = state_r;
      cnt_nxt   = cnt_r;
      wr_en     = 1'b0;
      wr_idx    = cnt_r;
      err_nxt   = 1'b0;
      push_nxt  = 1'b0;
      case (state_r)
         IDLE: begin
            if (acc) begin
               if (in_sop && !in_eop) begin
                  wr_en     = 1'b1;
                  wr_idx    = '0;
                  cnt_nxt   = CNT_W'(1);
                  state_nxt = ASM;
               end else begin
                  // sop&eop, or a beat outside any packet.
                  err_nxt = 1'b1;
                  if (!in_sop && !in_eop)
                     state_nxt = DROP;
               end
            end
         end
         ASM: begin
            if (acc) begin
               wr_en = 1'b1;
               if (in_sop) begin
                  // A new sop aborts the partial packet and restarts from it.
                  err_nxt = 1'b1;
                  wr_idx  = '0;
                  cnt_nxt = CNT_W'(1);
                  if (in_eop) begin
                     cnt_nxt   = '0;
                     state_nxt = IDLE;
                  end
               end else if (cnt_r == LAST) begin
                  cnt_nxt = '0;
                  if (in_eop) begin
                     state_nxt = HOLD;
                  end else begin
                     err_nxt   = 1'b1;
                     state_nxt = DROP;
                  end
               end else begin
                  cnt_nxt = cnt_r + CNT_W'(1);
                  if (in_eop) begin
                     err_nxt   = 1'b1;
                     cnt_nxt   = '0;
                     state_nxt = IDLE;
                  end
               end
            end
         end
         DROP: begin
            if (acc && in_eop)
               state_nxt = IDLE;
         end
         HOLD: begin
            if (!cmd_full_r) begin
               push_nxt  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Control registers: state, beat index and the one-cycle strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         cnt_r     <= '0;
         cmd_vld_r <= 1'b0;
         err_vld_r <= 1'b0;
      end else begin
         state_r   <= state_nxt;
         cnt_r     <= cnt_nxt;
         cmd_vld_r <= push_nxt;
         err_vld_r <= err_nxt;
      end
   end

   // Assembly buffer: each accepted beat lands in its slot, LSB first.
   always_ff @(posedge clk) begin
      if (rst) begin
         asm_r <= '0;
      end else if (wr_en) begin
         for (int k = 0; k < BEATS; k++) begin
            if (wr_idx == CNT_W'(k))
               asm_r[k*IN_W +: IN_W] <= in_data;
         end
      end
   end

`ifdef OB_CMD_DESER_STATS_EN
   // Saturating counters of pushes and framing errors, stepped with the strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_cnt_r <= '0;
         err_cnt_r <= '0;
      end else begin
         if (push_nxt && cmd_cnt_r != 16'hFFFF)
            cmd_cnt_r <= cmd_cnt_r + 16'd1;
         if (err_nxt && err_cnt_r != 16'hFFFF)
            err_cnt_r <= err_cnt_r + 16'd1;
      end
   end
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ob_cmd_deser.sv
// Testbench for ob_cmd_deser: directed framing cases followed by randomized
// packet traffic with random back-pressure; a packet-level reference model
// feeds expected commands and error times into queues that a negedge
// monitor drains.
module tb_ob_cmd_deser;

   localparam int IN_W  = 32;
   localparam int CMD_W = 96;
   localparam int NB    = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_vld = 1'b0;
   logic             in_sop = 1'b0;
   logic             in_eop = 1'b0;
   logic [IN_W-1:0]  in_data = '0;
   logic             in_rdy;
   logic             cmd_full_r = 1'b0;
   logic             cmd_vld_r;
   logic [CMD_W-1:0] cmd_r;
   logic             err_vld_r;
`ifdef OB_CMD_DESER_STATS_EN
   logic [15:0]      cmd_cnt_r;
   logic [15:0]      err_cnt_r;
`endif

   ob_cmd_deser #(.IN_W(IN_W), .CMD_W(CMD_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_vld     (in_vld),
      .in_sop     (in_sop),
      .in_eop     (in_eop),
      .in_data    (in_data),
      .in_rdy     (in_rdy),
      .cmd_full_r (cmd_full_r),
      .cmd_vld_r  (cmd_vld_r),
      .cmd_r      (cmd_r),
      .err_vld_r  (err_vld_r)
`ifdef OB_CMD_DESER_STATS_EN
      ,
      .cmd_cnt_r  (cmd_cnt_r),
      .err_cnt_r  (err_cnt_r)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [CMD_W-1:0] cmd;
      int               stamp;
   } exp_cmd_t;

   exp_cmd_t qc[$];
   int       eq[$];

   int n_chk  = 0;
   int n_pass = 0;

   bit mon_en     = 1'b0;
   bit full_force = 1'b0;
   int full_pct   = 0;
   bit gaps_en    = 1'b0;

   // Packet-level reference state
   bit          m_coll = 1'b0;
   bit          m_drop = 1'b0;
   logic [31:0] m_beats[$];
   int          m_pushes = 0;
   int          m_errs   = 0;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0b expected %0b at cycle %0d", name, act, exp, cyc);
   endtask

   task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
   endtask

   task automatic model_reset();
      m_coll = 1'b0;
      m_drop = 1'b0;
      m_beats.delete();
      m_pushes = 0;
      m_errs   = 0;
   endtask

   task automatic model_err(input int a);
      eq.push_back(a);
      m_errs++;
   endtask

   // One accepted beat, judged by packet rules: a packet is exactly NB beats,
   // sop on the first, eop on the last, and nothing outside a packet.
   task automatic model_beat(input bit s, input bit e, input logic [31:0] d, input int a);
      logic [CMD_W-1:0] c;
      if (m_drop) begin
         if (e) m_drop = 1'b0;
         return;
      end
      if (s) begin
         if (m_coll || e) model_err(a);
         if (e) begin
            m_coll = 1'b0;
         end else begin
            m_beats.delete();
            m_beats.push_back(d);
            m_coll = 1'b1;
         end
      end else if (!m_coll) begin
         model_err(a);
         m_drop = !e;
      end else begin
         m_beats.push_back(d);
         if (m_beats.size() == NB) begin
            m_coll = 1'b0;
            if (e) begin
               c = '0;
               foreach (m_beats[k]) c[k*IN_W +: IN_W] = m_beats[k];
               qc.push_back('{cmd: c, stamp: a});
               m_pushes++;
            end else begin
               model_err(a);
               m_drop = 1'b1;
            end
         end else if (e) begin
            model_err(a);
            m_coll = 1'b0;
         end
      end
   endtask

   // Drive one cycle of inputs just after the clock edge; the beat is taken
   // on the following edge if the DUT is ready and not in reset.
   task automatic cyc_drive(input bit r, input bit v, input bit s, input bit e,
                            input logic [31:0] d, output bit acc);
      @(posedge clk);
      #1;
      rst        = r;
      in_vld     = v;
      in_sop     = s;
      in_eop     = e;
      in_data    = d;
      cmd_full_r = full_force ? 1'b1 : ($urandom_range(99) < full_pct);
      acc        = v && !r && in_rdy;
      if (r) model_reset();
      else if (acc) model_beat(s, e, d, cyc + 1);
   endtask

   task automatic idle(input int n);
      bit a;
      repeat (n) cyc_drive(1'b0, 1'b0, 1'b0, 1'b0, $urandom, a);
   endtask

   task automatic send_beat(input bit s, input bit e, input logic [31:0] d);
      bit a;
      a = 1'b0;
      for (int t = 0; t < 60 && !a; t++) begin
         if (gaps_en && $urandom_range(3) == 0) idle(1);
         cyc_drive(1'b0, 1'b1, s, e, d, a);
      end
      if (!a) chk1("beat_accept_timeout", 1'b0, 1'b1);
   endtask

   task automatic send_pkt3(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
      send_beat(1'b1, 1'b0, d0);
      send_beat(1'b0, 1'b0, d1);
      send_beat(1'b0, 1'b1, d2);
   endtask

   task automatic do_reset(input int n);
      bit a;
      idle(1);
      for (int t = 0; t < 40 && qc.size() != 0; t++) idle(1);
      if (qc.size() != 0) chkw("drain_before_reset", 128'(qc.size()), 128'd0);
      repeat (n) cyc_drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), $urandom, a);
   endtask

   // Monitor: compares strobes, readiness and held data against the queues.
   always @(negedge clk) begin
      bit exp_vld, in_hold, exp_err;
      static bit full_prev = 1'b0;
      if (mon_en) begin
         exp_vld = (qc.size() > 0) && (cyc >= qc[0].stamp + 1) && !full_prev;
         in_hold = (qc.size() > 0) && (cyc >= qc[0].stamp);
         chk1("cmd_vld", cmd_vld_r, exp_vld);
         chk1("in_rdy", in_rdy, !(in_hold && !exp_vld));
         if (in_hold) chkw("cmd_data", 128'(cmd_r), 128'(qc[0].cmd));
         if (exp_vld) void'(qc.pop_front());
         exp_err = (eq.size() > 0) && (eq[0] == cyc);
         chk1("err_vld", err_vld_r, exp_err);
         if (exp_err) void'(eq.pop_front());
      end
      full_prev = cmd_full_r;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit a;
      int kind, len;
      repeat (3) cyc_drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, a);
      chk1("rst_cmd_vld", cmd_vld_r, 1'b0);
      chk1("rst_err_vld", err_vld_r, 1'b0);
      chkw("rst_cmd_r", 128'(cmd_r), 128'd0);
      chk1("rst_in_rdy", in_rdy, 1'b1);
`ifdef OB_CMD_DESER_STATS_EN
      chkw("rst_cmd_cnt", 128'(cmd_cnt_r), 128'd0);
      chkw("rst_err_cnt", 128'(err_cnt_r), 128'd0);
`endif
      mon_en = 1'b1;

      // Basic packet, no back-pressure.
      send_pkt3(32'h11111111, 32'h22222222, 32'h33333333);
      idle(4);
      // Same packet held by a full queue for several cycles.
      full_force = 1'b1;
      send_pkt3(32'h11111111, 32'h22222222, 32'h33333333);
      idle(5);
      full_force = 1'b0;
      idle(4);
      // sop, data, sop, data, data+eop: one error, command from second sop.
      send_beat(1'b1, 1'b0, 32'hAAAA0000);
      send_beat(1'b0, 1'b0, 32'hAAAA0001);
      send_pkt3(32'hBBBB0000, 32'hBBBB0001, 32'hBBBB0002);
      idle(4);
      // Over-long packet: error on the third beat, dropped through eop.
      send_beat(1'b1, 1'b0, 32'hC0);
      send_beat(1'b0, 1'b0, 32'hC1);
      send_beat(1'b0, 1'b0, 32'hC2);
      send_beat(1'b0, 1'b1, 32'hC3);
      idle(2);
      // Short packet, then a clean one.
      send_beat(1'b1, 1'b0, 32'hD0);
      send_beat(1'b0, 1'b1, 32'hD1);
      send_pkt3(32'hE0E0E0E0, 32'hE1E1E1E1, 32'hE2E2E2E2);
      idle(4);
      // Out-of-packet beats and sop&eop.
      send_beat(1'b0, 1'b0, 32'hF0);
      send_beat(1'b1, 1'b0, 32'hF1);
      send_beat(1'b0, 1'b1, 32'hF2);
      send_beat(1'b1, 1'b1, 32'hF3);
      send_beat(1'b0, 1'b1, 32'hF4);
      idle(3);
      // Reset during beat 2, then a clean packet.
      do_reset(1);
      send_beat(1'b1, 1'b0, 32'h51515151);
      cyc_drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h52525252, a);
      send_pkt3(32'h61616161, 32'h62626262, 32'h63636363);
      idle(4);
`ifdef OB_CMD_DESER_STATS_EN
      chkw("stats_cmd_cnt_after_reset", 128'(cmd_cnt_r), 128'd1);
`endif

      // Randomized traffic with gaps, back-pressure and occasional resets.
      gaps_en  = 1'b1;
      full_pct = 30;
      for (int p = 0; p < 300; p++) begin
         kind = $urandom_range(9);
         if (kind <= 5) begin
            send_pkt3($urandom, $urandom, $urandom);
         end else if (kind == 6) begin
            len = $urandom_range(2, 1);
            for (int b = 0; b < len; b++) send_beat(b == 0, b == len - 1, $urandom);
         end else if (kind == 7) begin
            len = $urandom_range(5, 4);
            for (int b = 0; b < len; b++) send_beat(b == 0, b == len - 1, $urandom);
         end else begin
            len = $urandom_range(4, 1);
            for (int b = 0; b < len; b++) send_beat(1'($urandom), 1'($urandom), $urandom);
         end
         if ($urandom_range(39) == 0) do_reset($urandom_range(2, 1));
      end

      full_pct = 0;
      gaps_en  = 1'b0;
      idle(10);
      chkw("cmd_queue_empty", 128'(qc.size()), 128'd0);
      chkw("err_queue_empty", 128'(eq.size()), 128'd0);
`ifdef OB_CMD_DESER_STATS_EN
      chkw("stats_cmd_cnt", 128'(cmd_cnt_r), 128'(m_pushes));
      chkw("stats_err_cnt", 128'(err_cnt_r), 128'(m_errs));
`endif
      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
